// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operand handshake in, registered result handshake out.
interface alu_seq_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] LHS;
   logic [WIDTH-1:0] RHS;
   logic [3:0]       Function;
   logic             In_Valid;
   logic             In_Ready;
   logic [WIDTH-1:0] Result;
   logic             Zero;
   logic             Out_Valid;
   logic             Out_Ready;
   logic             Busy;

   modport master (
      output LHS, RHS, Function, In_Valid, Out_Ready,
      input  In_Ready, Result, Zero, Out_Valid, Busy
   );

   modport slave (
      input  LHS, RHS, Function, In_Valid, Out_Ready,
      output In_Ready, Result, Zero, Out_Valid, Busy
   );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops, shifts iterate one bit per cycle.
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic      Clock,
   input  logic      Reset_n,
   alu_seq_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] work, result, alu_res, sh_res;
   logic             zero;
   logic [SHW-1:0]   cnt, amt;
   logic [3:0]       sop;
   logic             in_ready, accept, xfer, is_shift, go_shift;

   assign amt      = bus.RHS[SHW-1:0];
   assign is_shift = (bus.Function == 4'b0001) || (bus.Function == 4'b0101) ||
                     (bus.Function == 4'b1101);
   assign go_shift = is_shift && (amt != '0);

   assign in_ready = (state == IDLE) || ((state == DONE) && bus.Out_Ready);
   assign accept   = bus.In_Valid && in_ready;
   assign xfer     = (state == DONE) && bus.Out_Ready;

   // Shift opcodes only reach this path with amount 0, so they pass LHS through.
   always_comb begin
      alu_res = '0;
      case (bus.Function)
         4'b0000: alu_res = bus.LHS + bus.RHS;
         4'b1000: alu_res = bus.LHS - bus.RHS;
         4'b0010: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.LHS) < $signed(bus.RHS))};
         4'b0011: alu_res = {{(WIDTH-1){1'b0}}, (bus.LHS < bus.RHS)};
         4'b0100: alu_res = bus.LHS ^ bus.RHS;
         4'b0110: alu_res = bus.LHS | bus.RHS;
         4'b0111: alu_res = bus.LHS & bus.RHS;
         4'b0001,
         4'b0101,
         4'b1101: alu_res = bus.LHS;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      sh_res = work;
      case (sop)
         4'b0001: sh_res = {work[WIDTH-2:0], 1'b0};
         4'b0101: sh_res = {1'b0, work[WIDTH-1:1]};
         4'b1101: sh_res = {work[WIDTH-1], work[WIDTH-1:1]};
         default: sh_res = work;
      endcase
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = go_shift ? SHIFT : DONE;
         SHIFT:   if (cnt == SHW'(1)) state_nx = DONE;
         DONE: begin
            if (accept)    state_nx = go_shift ? SHIFT : DONE;
            else if (xfer) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         result <= '0;
         zero   <= 1'b1;
         cnt    <= '0;
         work   <= '0;
         sop    <= '0;
      end else if (accept) begin
         if (go_shift) begin
            work <= bus.LHS;
            cnt  <= amt;
            sop  <= bus.Function;
         end else begin
            result <= alu_res;
            zero   <= (alu_res == '0);
         end
      end else if (state == SHIFT) begin
         work <= sh_res;
         cnt  <= cnt - SHW'(1);
         if (cnt == SHW'(1)) begin
            result <= sh_res;
            zero   <= (sh_res == '0);
         end
      end
   end

   assign bus.In_Ready  = in_ready;
   assign bus.Result    = result;
   assign bus.Zero      = zero;
   assign bus.Out_Valid = (state == DONE);
   assign bus.Busy      = (state == SHIFT);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: 32-bit instance for the main ops, 8-bit instance for narrow shifts.
module tb_alu_seq;

   logic clk = 1'b0;
   logic rst_n;
   int   passed = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(32)) b32 ();
   alu_seq_if #(.WIDTH(8))  b8 ();

   alu_seq #(.WIDTH(32)) dut32 (.Clock(clk), .Reset_n(rst_n), .bus(b32.slave));
   alu_seq #(.WIDTH(8))  dut8  (.Clock(clk), .Reset_n(rst_n), .bus(b8.slave));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n        = 1'b0;
      b32.In_Valid = 1'b0; b32.Out_Ready = 1'b0;
      b32.LHS = '0; b32.RHS = '0; b32.Function = 4'h0;
      b8.In_Valid  = 1'b0; b8.Out_Ready  = 1'b1;
      b8.LHS = '0; b8.RHS = '0; b8.Function = 4'h0;
      tick; tick;
      rst_n = 1'b1;

      chk("rst_out_valid", b32.Out_Valid, 0);
      chk("rst_result",    b32.Result,    0);
      chk("rst_zero",      b32.Zero,      1);
      chk("rst_busy",      b32.Busy,      0);
      chk("rst_in_ready",  b32.In_Ready,  1);

      // ADD wraps to zero
      b32.LHS = 32'hFFFF_FFFF; b32.RHS = 32'h1; b32.Function = 4'b0000;
      b32.In_Valid = 1'b1; b32.Out_Ready = 1'b1;
      tick;
      b32.In_Valid = 1'b0;
      chk("add_valid",  b32.Out_Valid, 1);
      chk("add_result", b32.Result,    0);
      chk("add_zero",   b32.Zero,      1);
      tick;
      chk("add_drain",  b32.Out_Valid, 0);

      // SRA by 4, with junk requests offered mid-shift
      b32.LHS = 32'h8000_0000; b32.RHS = 32'h24; b32.Function = 4'b1101;
      b32.In_Valid = 1'b1;
      tick;
      chk("sra_busy0",     b32.Busy,     1);
      chk("sra_in_ready0", b32.In_Ready, 0);
      b32.LHS = 32'h123; b32.RHS = 32'h7; b32.Function = 4'b0000;
      for (int i = 1; i < 4; i++) begin
         tick;
         chk("sra_busy",  b32.Busy,      1);
         chk("sra_valid", b32.Out_Valid, 0);
      end
      tick;
      b32.In_Valid = 1'b0;
      chk("sra_valid_rise", b32.Out_Valid, 1);
      chk("sra_busy_done",  b32.Busy,      0);
      chk("sra_result",     b32.Result,    32'hF800_0000);
      chk("sra_zero",       b32.Zero,      0);
      tick;
      chk("sra_drain", b32.Out_Valid, 0);

      // Back-to-back single-cycle ops
      b32.LHS = 32'hFFFF_FFFF; b32.RHS = 32'h1; b32.Function = 4'b0010;
      b32.In_Valid = 1'b1;
      tick;
      chk("slt_result", b32.Result, 1);
      b32.Function = 4'b0011;
      tick;
      chk("sltu_valid",  b32.Out_Valid, 1);
      chk("sltu_result", b32.Result,    0);
      chk("sltu_zero",   b32.Zero,      1);
      b32.LHS = 32'h5; b32.RHS = 32'h3; b32.Function = 4'b1111;
      tick;
      chk("illegal_result", b32.Result, 0);
      b32.Function = 4'b1000;
      tick;
      chk("sub_result", b32.Result, 2);
      chk("sub_zero",   b32.Zero,   0);
      b32.In_Valid = 1'b0;
      tick;
      chk("b2b_drain", b32.Out_Valid, 0);

      // Shift by zero takes the single-cycle path
      b32.LHS = 32'h0000_ABCD; b32.RHS = 32'h20; b32.Function = 4'b0001;
      b32.In_Valid = 1'b1;
      tick;
      b32.In_Valid = 1'b0;
      chk("sll0_valid",  b32.Out_Valid, 1);
      chk("sll0_result", b32.Result,    32'h0000_ABCD);
      tick;

      // Backpressure on an XOR result, then OR accepted on the release edge
      b32.LHS = 32'hF0F0_F0F0; b32.RHS = 32'hFF00_FF00; b32.Function = 4'b0100;
      b32.In_Valid = 1'b1; b32.Out_Ready = 1'b0;
      tick;
      b32.LHS = 32'h1; b32.RHS = 32'h2; b32.Function = 4'b0110;
      for (int i = 0; i < 5; i++) begin
         chk("bp_result",   b32.Result,    32'h0FF0_0FF0);
         chk("bp_valid",    b32.Out_Valid, 1);
         chk("bp_in_ready", b32.In_Ready,  0);
         tick;
      end
      b32.Out_Ready = 1'b1;
      #1;
      chk("bp_release_ready", b32.In_Ready, 1);
      tick;
      b32.In_Valid = 1'b0;
      chk("or_valid",  b32.Out_Valid, 1);
      chk("or_result", b32.Result,    3);
      tick;
      chk("or_drain", b32.Out_Valid, 0);

      // Reset during the third SHIFT cycle of an SLL by 20
      b32.LHS = 32'h1; b32.RHS = 32'd20; b32.Function = 4'b0001;
      b32.In_Valid = 1'b1;
      tick;
      b32.In_Valid = 1'b0;
      tick; tick;
      chk("mid_busy", b32.Busy, 1);
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      chk("mr_valid",    b32.Out_Valid, 0);
      chk("mr_result",   b32.Result,    0);
      chk("mr_zero",     b32.Zero,      1);
      chk("mr_busy",     b32.Busy,      0);
      chk("mr_in_ready", b32.In_Ready,  1);
      for (int i = 0; i < 20; i++) tick;
      chk("mr_no_emit", b32.Out_Valid, 0);

      // 8-bit instance: SLL by 7 (upper RHS bits ignored)
      b8.LHS = 8'h01; b8.RHS = 8'hFF; b8.Function = 4'b0001;
      b8.In_Valid = 1'b1;
      tick;
      b8.In_Valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         chk("w8_busy",  b8.Busy,      1);
         chk("w8_valid", b8.Out_Valid, 0);
         tick;
      end
      chk("w8_valid_rise", b8.Out_Valid, 1);
      chk("w8_result",     b8.Result,    8'h80);
      chk("w8_zero",       b8.Zero,      0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
